// File: rtl/mm_scheduler.sv
// mm_scheduler: instruction-level controller for the matrix-multiply engine.
// Accepts packed MM instructions on a valid/ready handshake, splits the node
// count into tiles of at most TILE_N nodes, and launches the engine once per
// tile (start pulse, then wait for done).
//
// Optional feature: define MM_TIMEOUT_EN to build a per-launch watchdog that
// abandons an instruction after TIMEOUT_CYCLES without mm_done.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   inst_valid/inst_ready     instruction handshake (ready only in IDLE)
//   inst_data[79:0]           packed instruction
//   mm_start_valid            one-cycle engine start pulse per tile
//   mm_done                   engine completion pulse (only honoured in WAIT)
//   mm_*_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b
//                             engine configuration for the current tile
//   busy                      instruction in progress
//   inst_done                 pulse when all tiles of an instruction finish
//   inst_err                  pulse when an instruction is rejected/times out

module mm_scheduler #(
  parameter int unsigned TILE_N         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [79:0] inst_data,
  output logic        mm_start_valid,
  input  logic        mm_done,
  output logic [12:0] mm_weight_start_addr,
  output logic [10:0] mm_input_start_addr,
  output logic [10:0] mm_output_start_addr,
  output logic [8:0]  mm_bias_start_addr,
  output logic [7:0]  mm_ci,
  output logic [7:0]  mm_co,
  output logic [15:0] mm_n,
  output logic        mm_r,
  output logic        mm_a,
  output logic        mm_b,
  output logic        busy,
  output logic        inst_done,
  output logic        inst_err
);

  localparam int unsigned N_W  = 16;
  localparam int unsigned AD_W = 11;
  localparam logic [N_W-1:0] TILE = N_W'(TILE_N);

  if (TILE_N < 1 || TILE_N > 65535) begin : g_bad_tile_n
    $error("mm_scheduler: TILE_N must be in 1..65535");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mm_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  // Instruction word without the reserved top bit
  typedef struct packed {
    logic        b;
    logic        a;
    logic        r;
    logic [15:0] n;
    logic [7:0]  co;
    logic [7:0]  ci;
    logic [8:0]  bias;
    logic [10:0] out_addr;
    logic [10:0] in_addr;
    logic [12:0] weight;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t         state, next_state;
  inst_t          inst_q;
  logic [N_W-1:0] remaining;

  logic           accept;
  logic           inst_ok;
  logic [N_W-1:0] rem_after;
  logic [AD_W-1:0] in_step, out_step;

  logic unused_rsvd;
  assign unused_rsvd = inst_data[79];

  // Next-cycle values of the registered outputs
  logic            ready_nxt, start_nxt, busy_nxt, done_nxt, err_nxt;
  logic [12:0]     weight_nxt;
  logic [10:0]     in_nxt, out_nxt;
  logic [8:0]      bias_nxt;
  logic [7:0]      ci_nxt, co_nxt;
  logic [N_W-1:0]  n_nxt, rem_nxt;
  logic            r_nxt, a_nxt, b_nxt;

  function automatic logic [N_W-1:0] tile_min(input logic [N_W-1:0] v);
    return (v > TILE) ? TILE : v;
  endfunction

  assign accept    = inst_valid & inst_ready;
  assign inst_ok   = (inst_q.ci != '0) && (inst_q.co != '0) && (inst_q.n != '0);
  assign rem_after = remaining - mm_n;
  // Strides are formed at 24 bits, then only the low address bits are kept
  assign in_step   = AD_W'(24'(mm_n) * 24'(mm_ci));
  assign out_step  = AD_W'(24'(mm_n) * 24'(mm_co));

`ifdef MM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  // Counter holds (WAIT cycles - 1); firing at TIMEOUT_CYCLES-2 places the
  // err pulse exactly TIMEOUT_CYCLES cycles after the start pulse.
  assign wd_expired = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 2));

  // Watchdog: clears in LAUNCH, counts in WAIT
  always_ff @(posedge clk or negedge rstn) begin : wd_reg
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin : state_reg
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin : next_state_comb
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_CHECK;
      S_CHECK:  next_state = inst_ok ? S_LAUNCH : S_IDLE;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT: begin
        if (mm_done) begin
          next_state = S_NEXT;
`ifdef MM_TIMEOUT_EN
        end else if (wd_expired) begin
          next_state = S_IDLE;
`endif
        end
      end
      S_NEXT:   next_state = (rem_after == '0) ? S_FIN : S_LAUNCH;
      S_FIN:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output logic: computes what the output registers load this edge
  always_comb begin : output_comb
    weight_nxt = mm_weight_start_addr;
    in_nxt     = mm_input_start_addr;
    out_nxt    = mm_output_start_addr;
    bias_nxt   = mm_bias_start_addr;
    ci_nxt     = mm_ci;
    co_nxt     = mm_co;
    n_nxt      = mm_n;
    r_nxt      = mm_r;
    a_nxt      = mm_a;
    b_nxt      = mm_b;
    rem_nxt    = remaining;
    err_nxt    = 1'b0;
    ready_nxt  = (next_state == S_IDLE);
    busy_nxt   = (next_state != S_IDLE);
    start_nxt  = (next_state == S_LAUNCH);
    done_nxt   = (next_state == S_FIN);

    case (state)
      S_CHECK: begin
        if (inst_ok) begin
          weight_nxt = inst_q.weight;
          in_nxt     = inst_q.in_addr;
          out_nxt    = inst_q.out_addr;
          bias_nxt   = inst_q.bias;
          ci_nxt     = inst_q.ci;
          co_nxt     = inst_q.co;
          r_nxt      = inst_q.r;
          a_nxt      = inst_q.a;
          b_nxt      = inst_q.b;
          rem_nxt    = inst_q.n;
          n_nxt      = tile_min(inst_q.n);
        end else begin
          err_nxt = 1'b1;
        end
      end
      S_NEXT: begin
        // Bases wrap modulo 2^11 by plain truncation
        rem_nxt = rem_after;
        in_nxt  = mm_input_start_addr + in_step;
        out_nxt = mm_output_start_addr + out_step;
        if (rem_after != '0) n_nxt = tile_min(rem_after);
      end
`ifdef MM_TIMEOUT_EN
      S_WAIT: begin
        if (!mm_done && wd_expired) err_nxt = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Instruction latch on accept
  always_ff @(posedge clk or negedge rstn) begin : inst_reg
    if (!rstn) begin
      inst_q <= '0;
    end else if (accept) begin
      inst_q <= inst_t'(inst_data[78:0]);
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rstn) begin : out_reg
    if (!rstn) begin
      inst_ready           <= 1'b0;
      mm_start_valid       <= 1'b0;
      mm_weight_start_addr <= '0;
      mm_input_start_addr  <= '0;
      mm_output_start_addr <= '0;
      mm_bias_start_addr   <= '0;
      mm_ci                <= '0;
      mm_co                <= '0;
      mm_n                 <= '0;
      mm_r                 <= 1'b0;
      mm_a                 <= 1'b0;
      mm_b                 <= 1'b0;
      busy                 <= 1'b0;
      inst_done            <= 1'b0;
      inst_err             <= 1'b0;
      remaining            <= '0;
    end else begin
      inst_ready           <= ready_nxt;
      mm_start_valid       <= start_nxt;
      mm_weight_start_addr <= weight_nxt;
      mm_input_start_addr  <= in_nxt;
      mm_output_start_addr <= out_nxt;
      mm_bias_start_addr   <= bias_nxt;
      mm_ci                <= ci_nxt;
      mm_co                <= co_nxt;
      mm_n                 <= n_nxt;
      mm_r                 <= r_nxt;
      mm_a                 <= a_nxt;
      mm_b                 <= b_nxt;
      busy                 <= busy_nxt;
      inst_done            <= done_nxt;
      inst_err             <= err_nxt;
      remaining            <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_mm_scheduler.sv
// Testbench for mm_scheduler: directed scenarios plus randomized instructions
// checked against a tile-list model computed from the instruction fields.
module tb_mm_scheduler;

  localparam int TILE = 64;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_valid;
  logic        inst_ready;
  logic [79:0] inst_data;
  logic        mm_start_valid;
  logic        mm_done;
  logic [12:0] mm_weight_start_addr;
  logic [10:0] mm_input_start_addr;
  logic [10:0] mm_output_start_addr;
  logic [8:0]  mm_bias_start_addr;
  logic [7:0]  mm_ci;
  logic [7:0]  mm_co;
  logic [15:0] mm_n;
  logic        mm_r, mm_a, mm_b;
  logic        busy, inst_done, inst_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mm_scheduler #(.TILE_N(TILE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .mm_start_valid(mm_start_valid), .mm_done(mm_done),
    .mm_weight_start_addr(mm_weight_start_addr),
    .mm_input_start_addr(mm_input_start_addr),
    .mm_output_start_addr(mm_output_start_addr),
    .mm_bias_start_addr(mm_bias_start_addr),
    .mm_ci(mm_ci), .mm_co(mm_co), .mm_n(mm_n),
    .mm_r(mm_r), .mm_a(mm_a), .mm_b(mm_b),
    .busy(busy), .inst_done(inst_done), .inst_err(inst_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // flags = {reserved, b, a, r}
  function automatic logic [79:0] mk(input int w, input int in_a, input int out_a,
                                     input int bias, input int ci, input int co,
                                     input int n, input logic [3:0] flags);
    return {flags, 16'(n), 8'(co), 8'(ci), 9'(bias), 11'(out_a), 11'(in_a), 13'(w)};
  endfunction

  // Present an instruction and wait (bounded) for the accepting edge
  task automatic send(input logic [79:0] d, output int acc);
    int w;
    w = 0;
    inst_valid = 1'b1;
    inst_data  = d;
    while (inst_ready !== 1'b1 && w < 200) begin tick(); w++; end
    n_checks++;
    if (inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept: inst_ready=%b after %0d cycles, required 1", inst_ready, w);
    end
    acc = cyc;
    tick();
    inst_valid = 1'b0;
  endtask

  // Engine model: expects each tile launch at its fixed cycle, returns done
  // after 'delay' WAIT cycles, and checks the final inst_done pulse.
  task automatic serve(input logic [79:0] d, input int acc, input int delay,
                       input bit bp, input logic [79:0] nd, output int fin);
    int rem, tn, inb, outb, ci, co, t_exp, dc;
    logic [78:0] exp_cfg;
    rem  = int'(d[75:60]);
    ci   = int'(d[51:44]);
    co   = int'(d[59:52]);
    inb  = int'(d[23:13]);
    outb = int'(d[34:24]);
    t_exp = acc + 2;
    dc = 0;
    while (rem > 0) begin
      tn = (rem < TILE) ? rem : TILE;
      while (cyc < t_exp) begin
        n_checks++;
        if ({mm_start_valid, inst_done, inst_err} !== 3'b000) begin
          n_fail++;
          $display("FAIL idle_gap: start/done/err=%b at cycle %0d, required 000 before %0d",
                   {mm_start_valid, inst_done, inst_err}, cyc, t_exp);
        end
        tick();
      end
      exp_cfg = {16'(tn), 11'(inb), 11'(outb), d[12:0], d[43:35], d[51:44], d[59:52],
                 d[76], d[77], d[78]};
      n_checks++;
      if (mm_start_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL launch: start=%b busy=%b at cycle %0d, required 1 1", mm_start_valid, busy, cyc);
      end
      n_checks++;
      if ({mm_n, mm_input_start_addr, mm_output_start_addr, mm_weight_start_addr,
           mm_bias_start_addr, mm_ci, mm_co, mm_r, mm_a, mm_b} !== exp_cfg) begin
        n_fail++;
        $display("FAIL tile_cfg: n=%0d in=%h out=%h w=%h bias=%h, required n=%0d in=%h out=%h w=%h bias=%h",
                 mm_n, mm_input_start_addr, mm_output_start_addr, mm_weight_start_addr,
                 mm_bias_start_addr, tn, inb, outb, d[12:0], d[43:35]);
      end
      if (bp) begin
        inst_valid = 1'b1;
        inst_data  = nd;
      end
      tick();
      for (int i = 0; i < delay; i++) begin
        n_checks++;
        if ({mm_start_valid, mm_n, inst_ready, inst_done} !== {1'b0, 16'(tn), 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL wait_hold: start=%b n=%0d ready=%b done=%b, required 0 %0d 0 0",
                   mm_start_valid, mm_n, inst_ready, inst_done, tn);
        end
        if (i == delay - 1) begin
          mm_done = 1'b1;
          dc = cyc;
        end
        tick();
      end
      mm_done = 1'b0;
      rem  = rem - tn;
      inb  = (inb + tn * ci) % 2048;
      outb = (outb + tn * co) % 2048;
      t_exp = dc + 2;
    end
    while (cyc < t_exp) begin
      n_checks++;
      if ({mm_start_valid, inst_done, inst_err} !== 3'b000) begin
        n_fail++;
        $display("FAIL fin_gap: start/done/err=%b, required 000", {mm_start_valid, inst_done, inst_err});
      end
      tick();
    end
    n_checks++;
    if ({inst_done, inst_err, busy, mm_start_valid} !== 4'b1010) begin
      n_fail++;
      $display("FAIL inst_done: done/err/busy/start=%b at cycle %0d, required 1010",
               {inst_done, inst_err, busy, mm_start_valid}, cyc);
    end
    fin = cyc;
    tick();
    n_checks++;
    if ({inst_done, busy, inst_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL post_fin: done/busy/ready=%b, required 001", {inst_done, busy, inst_ready});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({inst_ready, mm_start_valid, mm_weight_start_addr, mm_input_start_addr,
         mm_output_start_addr, mm_bias_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b,
         busy, inst_done, inst_err} !== 84'd0) begin
      n_fail++;
      $display("FAIL reset_values: outputs nonzero in reset, required all 0");
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if ({inst_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_idle: ready/busy=%b, required 10", {inst_ready, busy});
    end
  endtask

  task automatic test_single();
    int acc, fin;
    logic [79:0] d;
    d = mk(13'h155, 11'h100, 11'h200, 9'h0AA, 4, 2, 10, 4'b0101);
    send(d, acc);
    serve(d, acc, 30, 1'b0, '0, fin);
  endtask

  task automatic test_tiling();
    int acc, fin;
    logic [79:0] d;
    d = mk(13'h1ABC, 0, 11'h010, 9'h123, 2, 3, 150, 4'b0110);
    send(d, acc);
    serve(d, acc, 4, 1'b0, '0, fin);
  endtask

  task automatic test_reject();
    int acc;
    logic [79:0] d [3];
    d[0] = mk(1, 2, 3, 4, 5, 6, 0, 4'b0000);
    d[1] = mk(1, 2, 3, 4, 5, 0, 9, 4'b0111);
    d[2] = mk(1, 2, 3, 4, 0, 6, 9, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      send(d[k], acc);
      n_checks++;
      if ({mm_start_valid, inst_err, inst_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL reject_check_cycle[%0d]: start/err/ready=%b, required 000", k,
                 {mm_start_valid, inst_err, inst_ready});
      end
      tick();
      n_checks++;
      if ({mm_start_valid, inst_err, inst_ready, busy, inst_done} !== 5'b01100) begin
        n_fail++;
        $display("FAIL reject[%0d]: start/err/ready/busy/done=%b at acc+%0d, required 01100", k,
                 {mm_start_valid, inst_err, inst_ready, busy, inst_done}, cyc - acc);
      end
      tick();
      n_checks++;
      if ({mm_start_valid, inst_err} !== 2'b00) begin
        n_fail++;
        $display("FAIL reject_pulse[%0d]: start/err=%b, required 00", k, {mm_start_valid, inst_err});
      end
    end
  endtask

  task automatic test_wrap();
    int acc, fin;
    logic [79:0] d;
    d = mk(7, 11'h7F0, 11'h7FF, 3, 1, 200, 80, 4'b1000);
    send(d, acc);
    serve(d, acc, 2, 1'b0, '0, fin);
  endtask

  task automatic test_back_to_back();
    int acc, acc2, fin;
    logic [79:0] da, db;
    da = mk(11, 22, 33, 44, 3, 5, 5, 4'b0001);
    db = mk(99, 88, 77, 66, 7, 9, 70, 4'b0010);
    send(da, acc);
    serve(da, acc, 6, 1'b1, db, fin);
    send(db, acc2);
    n_checks++;
    if (acc2 !== fin + 1) begin
      n_fail++;
      $display("FAIL backpressure_accept: accepted at %0d, required %0d", acc2, fin + 1);
    end
    serve(db, acc2, 3, 1'b0, '0, fin);
  endtask

  task automatic test_reset_mid();
    int acc;
    logic [79:0] d;
    d = mk(5, 6, 7, 8, 2, 2, 40, 4'b0111);
    send(d, acc);
    while (cyc < acc + 2) tick();
    n_checks++;
    if (mm_start_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_launch: start=%b, required 1", mm_start_valid);
    end
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({inst_ready, mm_start_valid, mm_weight_start_addr, mm_input_start_addr,
         mm_output_start_addr, mm_bias_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b,
         busy, inst_done, inst_err} !== 84'd0) begin
      n_fail++;
      $display("FAIL rst_mid_values: busy=%b n=%0d ci=%0d, required all outputs 0", busy, mm_n, mm_ci);
    end
    tick();
    rstn = 1'b1;
    tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({inst_done, inst_err, mm_start_valid, busy, inst_ready} !== 5'b00001) begin
        n_fail++;
        $display("FAIL rst_mid_after: done/err/start/busy/ready=%b, required 00001",
                 {inst_done, inst_err, mm_start_valid, busy, inst_ready});
      end
      tick();
    end
  endtask

  task automatic test_random();
    int acc, fin;
    logic [79:0] d;
    for (int k = 0; k < 12; k++) begin
      d = mk(int'($urandom_range(0, 8191)), int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 511)),
             int'($urandom_range(1, 255)), int'($urandom_range(1, 255)),
             int'($urandom_range(1, 200)), 4'($urandom_range(0, 15)));
      send(d, acc);
      serve(d, acc, int'($urandom_range(1, 6)), 1'b0, '0, fin);
    end
  endtask

`ifdef MM_TIMEOUT_EN
  task automatic test_timeout();
    int acc, l;
    logic [79:0] d;
    d = mk(1, 2, 3, 4, 1, 1, 200, 4'b0000);
    send(d, acc);
    while (cyc < acc + 2) tick();
    l = cyc;
    n_checks++;
    if (mm_start_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_launch: start=%b, required 1", mm_start_valid);
    end
    tick();
    while (cyc < l + TO) begin
      n_checks++;
      if ({inst_err, mm_start_valid, inst_done, busy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL to_wait: err/start/done/busy=%b at L+%0d, required 0001",
                 {inst_err, mm_start_valid, inst_done, busy}, cyc - l);
      end
      tick();
    end
    n_checks++;
    if ({inst_err, busy, inst_ready, inst_done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL to_err: err/busy/ready/done=%b at L+%0d, required 1010",
               {inst_err, busy, inst_ready, inst_done}, cyc - l);
    end
    tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({mm_start_valid, inst_done, inst_err, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL to_late_done: start/done/err/busy=%b, required 0000",
                 {mm_start_valid, inst_done, inst_err, busy});
      end
      tick();
    end
  endtask
`endif

  initial begin
    rstn       = 1'b0;
    inst_valid = 1'b0;
    inst_data  = '0;
    mm_done    = 1'b0;
    tick();
    test_reset();
    test_single();
    test_tiling();
    test_reject();
    test_wrap();
    test_back_to_back();
    test_random();
`ifdef MM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_scheduler.md
Name: mm_scheduler

Overview:
Instruction-level controller for the matrix-multiply engine. It accepts packed MM instructions over a valid/ready handshake and splits each instruction's node count into tiles of at most TILE_N nodes. For every tile it drives the engine's parameter bus and a one-cycle start pulse, then waits for the engine's done pulse. It sits between the instruction decoder/dispatcher and the mm engine, and is the only driver of the engine's configuration inputs.

Parameters:
TILE_N, 64, max nodes per engine launch (1..65535)
TIMEOUT_CYCLES, 1048576, watchdog limit per launch (used only with MM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
inst_valid  in  1  instruction present
inst_ready  out  1  scheduler can accept an instruction
inst_data  in  80  packed instruction (field map below)
mm_start_valid  out  1  one-cycle engine start pulse
mm_done  in  1  engine completion pulse
mm_weight_start_addr  out  13  engine weight base
mm_input_start_addr  out  11  engine input base, current tile
mm_output_start_addr  out  11  engine output base, current tile
mm_bias_start_addr  out  9  engine bias base
mm_ci  out  8  input addresses per feature
mm_co  out  8  output addresses per feature
mm_n  out  16  node count of current tile
mm_r / mm_a / mm_b  out  1 each  relu / accumulate / bias enables
busy  out  1  instruction in progress
inst_done  out  1  one-cycle pulse when all tiles of an instruction finish
inst_err  out  1  one-cycle pulse when an instruction is rejected or times out

Behaviour:
- Reset is asynchronous and active-low (rstn), on a single clock clk.
- Reset values:
  - all mm_* outputs are 0; busy, inst_done and inst_err are 0; inst_ready is 0; FSM is in IDLE.
  - Reset mid-operation drops the current instruction. No done or err pulse is produced for it.
- inst_data field map:
  - [12:0] weight_start_addr; [23:13] input_start_addr; [34:24] output_start_addr; [43:35] bias_start_addr.
  - [51:44] ci; [59:52] co; [75:60] n.
  - [76] r; [77] a; [78] b; [79] reserved, ignored.
- inst_ready = 1 only in IDLE. An instruction is accepted when inst_valid & inst_ready are both high; the whole word is latched on that edge.
- FSM states:
  - IDLE: on accept go to CHECK.
  - CHECK: if ci==0 or co==0 or n==0, pulse inst_err and return to IDLE (no launch). Otherwise:
    - load remaining = n;
    - load tile bases from the instruction;
    - set mm_n = min(remaining, TILE_N);
    - drive all mm_* config outputs;
    - go to LAUNCH.
  - LAUNCH: mm_start_valid = 1 for exactly this cycle; go to WAIT.
  - WAIT: hold every config output stable. On mm_done go to NEXT. A mm_done seen in any other state is ignored.
  - NEXT: update for the next tile:
    - remaining -= mm_n;
    - mm_input_start_addr += mm_n*ci;
    - mm_output_start_addr += mm_n*co;
    - if remaining==0, go to FIN; otherwise set mm_n = min(remaining, TILE_N) and go to LAUNCH.
  - FIN: pulse inst_done for one cycle; go to IDLE.
- Config outputs are held after FIN until the next CHECK.
- Fixed latency: accept edge T, CHECK at T+1, first mm_start_valid at T+2. After mm_done at cycle D, the next start is at D+2, or inst_done is at D+2.
- Address arithmetic:
  - products are formed at 24 bits, then truncated to 11 bits;
  - base addresses wrap modulo 2^11 with no error.
- mm_weight_start_addr, mm_bias_start_addr, ci, co, r, a and b are identical for every tile of one instruction.
- busy = 1 in every state except IDLE.

Optional Feature:
MM_TIMEOUT_EN:
- Defined: a watchdog counter clears in LAUNCH and increments in WAIT. When it reaches TIMEOUT_CYCLES without mm_done, the scheduler pulses inst_err, abandons the remaining tiles, and returns to IDLE (no inst_done). A late mm_done arriving in IDLE is ignored.
- Not defined: no counter is built and WAIT blocks indefinitely.

Test Plan:
- Single tile. Instruction ci=4, co=2, n=10, input base 0x100, output base 0x200, TILE_N=64:
  - one mm_start_valid at accept+2, with mm_n=10;
  - mm_done returned 30 cycles later -> inst_done 2 cycles after mm_done; busy low the following cycle.
- Tiling. ci=2, co=3, n=150, input 0, output 0x10, TILE_N=64:
  - three launches with mm_n = 64, 64, 22;
  - input bases 0, 128, 256; output bases 0x10, 0xD0, 0x190;
  - weight/bias bases constant across all three.
- Reject. n=0, and separately co=0 -> inst_err pulse, no mm_start_valid, inst_ready high again 2 cycles after accept.
- Wrap. input base 0x7F0, ci=1, n=80, TILE_N=64 -> second tile input base is 0x030.
- Backpressure and reset:
  - inst_valid held high during WAIT -> inst_ready stays low and the instruction is accepted only after FIN;
  - rstn asserted during WAIT -> all outputs go to 0 immediately, and a later mm_done produces no pulse.
- Timeout (MM_TIMEOUT_EN, TIMEOUT_CYCLES=100): mm_done withheld -> inst_err exactly 100 cycles after LAUNCH, no further launches, FSM back in IDLE.
